// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and powers of ten for the matrix print formatter.
// Pure declarations: no latency and no flow control of its own.
package matrix_pkg;

   localparam int MAX_DIM = 5;

   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_ZERO  = 8'h30;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RD,
      S_RDW,
      S_SIGN,
      S_CONV,
      S_SEP,
      S_CR,
      S_LF,
      S_ERR,
      S_DONE
   } fmt_state_t;

   // POW10[i] = 10^i
   localparam logic [31:0] POW10 [10] = '{
      32'd1, 32'd10, 32'd100, 32'd1000, 32'd10000, 32'd100000,
      32'd1000000, 32'd10000000, 32'd100000000, 32'd1000000000
   };

endpackage

// File: rtl/bin2dec_serial.sv
// Serial magnitude-to-decimal digits by repeated subtraction, up to 10 cycles per power of ten.
// Backpressure: a presented digit stays valid and frozen while hold is high.
module bin2dec_serial #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] mag,
   input  logic              hold,
   output logic [3:0]        digit,
   output logic              digit_vld,
   output logic              last
);
   import matrix_pkg::*;

   logic [DATA_W-1:0] rem;
   logic [DATA_W-1:0] pow;
   logic [3:0]        idx;
   logic [3:0]        dig;
   logic              seen;
   logic              active;
   logic              present;

   assign pow = DATA_W'(POW10[idx]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem     <= '0;
         idx     <= '0;
         dig     <= '0;
         seen    <= 1'b0;
         active  <= 1'b0;
         present <= 1'b0;
      end else if (start) begin
         rem     <= mag;
         idx     <= 4'd9;
         dig     <= '0;
         seen    <= 1'b0;
         active  <= 1'b1;
         present <= 1'b0;
      end else if (active) begin
         if (present) begin
            if (!hold) begin
               present <= 1'b0;
               seen    <= 1'b1;
               dig     <= '0;
               if (idx == 4'd0) active <= 1'b0;
               else             idx    <= idx - 4'd1;
            end
         end else if (rem >= pow) begin
            rem <= rem - pow;
            dig <= dig + 4'd1;
         end else if (dig != 4'd0 || seen || idx == 4'd0) begin
            present <= 1'b1;
         end else begin
            // leading zero: skip this power without emitting
            idx <= idx - 4'd1;
         end
      end
   end

   assign digit     = dig;
   assign digit_vld = present;
   assign last      = present && (idx == 4'd0);

endmodule

// File: rtl/matrix_print_formatter.sv
// Reads an m x n row-major matrix from storage and streams it as ASCII decimal text.
// Latency: 2 cycles per read plus conversion; every byte waits on i_tx_ready with o_tx_data held.
module matrix_print_formatter #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 8,
   parameter int MAX_DIM = matrix_pkg::MAX_DIM
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [2:0]        i_m,
   input  logic [2:0]        i_n,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic [7:0]        o_tx_data,
   output logic              o_tx_valid,
   input  logic              i_tx_ready,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);
   import matrix_pkg::*;

   fmt_state_t        state, state_nxt;
   logic [ADDR_W-1:0] rd_addr;
   logic [2:0]        m_q, n_q, r_q, c_q;
   logic              err_q;
   logic              dims_bad;
   logic [DATA_W-1:0] mag;
   logic [3:0]        digit;
   logic              digit_vld, digit_last, b2d_hold;

   assign dims_bad = (i_m == 3'd0) || (int'(i_m) > MAX_DIM) ||
                     (i_n == 3'd0) || (int'(i_n) > MAX_DIM);

   // magnitude as unsigned so the most negative value converts correctly
   assign mag      = i_rd_data[DATA_W-1] ? -i_rd_data : i_rd_data;
   assign b2d_hold = !((state == S_CONV) && i_tx_ready);

   bin2dec_serial #(.DATA_W(DATA_W)) u_b2d (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (state == S_RDW),
      .mag       (mag),
      .hold      (b2d_hold),
      .digit     (digit),
      .digit_vld (digit_vld),
      .last      (digit_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         rd_addr <= '0;
         m_q     <= '0;
         n_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && i_start) begin
            m_q     <= i_m;
            n_q     <= i_n;
            r_q     <= '0;
            c_q     <= '0;
            rd_addr <= i_base_addr;
            err_q   <= dims_bad;
         end
         if (state == S_RDW) rd_addr <= rd_addr + 1'b1;
         if (state == S_SEP && i_tx_ready) c_q <= c_q + 3'd1;
         if (state == S_LF && i_tx_ready) begin
            c_q <= '0;
            r_q <= r_q + 3'd1;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      o_tx_valid = 1'b0;
      o_tx_data  = 8'h00;
      o_busy     = (state != S_IDLE) && (state != S_DONE);
      o_done     = (state == S_DONE);
      case (state)
         S_IDLE: if (i_start) state_nxt = dims_bad ? S_ERR : S_RD;
         S_RD:   state_nxt = S_RDW;
         S_RDW:  state_nxt = i_rd_data[DATA_W-1] ? S_SIGN : S_CONV;
         S_SIGN: begin
            o_tx_valid = 1'b1;
            o_tx_data  = CH_MINUS;
            if (i_tx_ready) state_nxt = S_CONV;
         end
         S_CONV: begin
            o_tx_valid = digit_vld;
            o_tx_data  = digit_vld ? (CH_ZERO + {4'b0000, digit}) : 8'h00;
            if (digit_vld && digit_last && i_tx_ready)
               state_nxt = (c_q == n_q - 3'd1) ? S_CR : S_SEP;
         end
         S_SEP: begin
            o_tx_valid = 1'b1;
            o_tx_data  = CH_SPACE;
            if (i_tx_ready) state_nxt = S_RD;
         end
         S_CR: begin
            o_tx_valid = 1'b1;
            o_tx_data  = CH_CR;
            if (i_tx_ready) state_nxt = S_LF;
         end
         S_LF: begin
            o_tx_valid = 1'b1;
            o_tx_data  = CH_LF;
            if (i_tx_ready) state_nxt = (r_q == m_q - 3'd1) ? S_DONE : S_RD;
         end
         // one-cycle dwell so o_err is visible while busy before the done pulse
         S_ERR:  state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign o_rd_addr = rd_addr;
   assign o_err     = err_q;

endmodule

// File: doc/matrix_print_formatter.md
# matrix_print_formatter

Streams one stored matrix out as ASCII text for the UART transmitter. Given a base address and dimensions, it reads elements sequentially from `Matrix_storage` through the display port of `Storage_Mux`. It converts each signed 32-bit element to decimal and hands bytes one at a time to the UART TX byte interface. It sits between storage and `uart_tx` inside the display path, and it is the formatting engine the Display_Subsystem invokes for matrix-print modes.

## Interface
- `DATA_W`, default 32: element width, two's complement.
- `ADDR_W`, default 8: storage address width.
- `MAX_DIM`, default 5: largest legal m or n.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `i_start` input 1: one-cycle start pulse. Only sampled in IDLE.
- `i_base_addr` input ADDR_W: address of element (0,0). Row-major layout.
- `i_m` input 3: row count. Latched on start.
- `i_n` input 3: column count. Latched on start.
- `o_rd_addr` output ADDR_W: storage read address.
- `i_rd_data` input DATA_W: storage read data. Valid one cycle after `o_rd_addr` is presented (synchronous read).
- `o_tx_data` output 8: byte to transmit.
- `o_tx_valid` output 1: byte available.
- `i_tx_ready` input 1: a byte transfers on a cycle where `o_tx_valid && i_tx_ready`.
- `o_busy` output 1: high from the accepted start until done.
- `o_done` output 1: one-cycle completion pulse.
- `o_err` output 1: sticky illegal-dimension flag. Cleared by the next accepted start.

## Operation
- Reset values:
  - `o_rd_addr=0`, `o_tx_data=0`.
  - `o_tx_valid=0`, `o_busy=0`, `o_done=0`, `o_err=0`.
  - State IDLE.
- Output format per row: elements separated by a single 0x20. The last element of the row is followed by 0x0D 0x0A. There is no trailing space.
- Number format:
  - Optional '-' (0x2D), then decimal digits with leading zeros suppressed.
  - A value of 0 prints as "0".
  - -2147483648 prints all 10 digits. The magnitude is computed as unsigned DATA_W.
- Element k (k = r·n + c) is read from address `i_base_addr + k`, taken modulo 2^ADDR_W, so the address wraps.
- States:
  - IDLE → on start: if m ∈ {0} or m > MAX_DIM, or n ∈ {0} or n > MAX_DIM, go to DONE with `o_err=1` and emit no bytes. Otherwise go to RD.
  - RD: drive the address → RDW.
  - RDW: capture `i_rd_data` → SIGN if negative, else CONV.
  - SIGN: emit '-' → CONV.
  - CONV: serial binary-to-decimal conversion. Subtract powers of ten from 10^9 down to 10^0, at most one subtraction per cycle. The digit count for each power is held in a digit register. Once a non-zero digit has been seen, or at the 10^0 digit, emit '0'+digit and wait for the handshake before moving to the next power.
  - SEP: emit 0x20 → RD (next column).
  - CR, then LF: emit → RD for the next row, or DONE after the last row.
  - DONE: pulse `o_done` for one cycle, drop `o_busy` → IDLE.
- `i_start` while busy is ignored.
- An asynchronous reset mid-stream returns the block to IDLE immediately. Any partial byte is abandoned, with `o_tx_valid` forced to 0.

## Timing
- Start → RD on the next cycle. `o_busy` rises the cycle after `i_start`.
- Read latency: 2 cycles from RD to the value being registered.
- `o_tx_data` must stay stable while `o_tx_valid=1` and `i_tx_ready=0`. `o_tx_valid` never drops without a transfer, except on reset.
- Within one element, the next byte can be presented the cycle after a transfer. Each digit also needs up to 9 subtraction cycles, plus one cycle per power of ten.
- `o_done` is asserted exactly 1 cycle after the final LF transfer. For the illegal-dimension case, it is asserted 2 cycles after start.

## Structure
- Shared package `matrix_pkg`:
  - `MAX_DIM`.
  - ASCII constants `CH_SPACE`, `CH_CR`, `CH_LF`, `CH_MINUS`, `CH_ZERO`.
  - The formatter state enum.
  - The `POW10` constant array of 10 × 32-bit values.
- One natural sub-module, `bin2dec_serial`. It takes a magnitude plus a start pulse and yields a digit, a digit_valid, and a last flag, and it has a `hold` input driven by the TX backpressure. The top module owns the read sequencing, separators and framing.

## Test plan
- 2×3 at base 0, contents 4 5 6 7 8 9, `i_tx_ready` tied to 1 → exactly "4 5 6\r\n7 8 9\r\n" (14 bytes). Check `o_done` one cycle after the last byte.
- 1×3 with values 0, -12, 2147483647 → "0 -12 2147483647\r\n".
- 1×1 with value 0x80000000 → "-2147483648\r\n".
- 2×2 at base 254, storage[254,255,0,1] = 1,2,3,4 → addresses wrap to 0 and 1, output "1 2\r\n3 4\r\n".
- Random `i_tx_ready` stalls on the 2×3 case → identical byte stream, and `o_tx_data` never changes while valid and not ready.
- Error and reset cases:
  - Start with m=0 → `o_err=1`, `o_done` pulse, no `o_tx_valid`.
  - Start with n=6 → same as m=0.
  - Assert `rst_n` low mid-digit → all outputs return to reset values. A following 1×1 print then works.
